expression_root_finder: RTL
===========================

# expression_root_finder

Inverse companion of the expression solver. The solver evaluates A·X² + B·X + C for a given X. This block takes coefficients A, B, C and a target value Y, and searches X over the full signed 8-bit range for a solution. It reports the smallest X with A·X² + B·X + C == Y, or reports that no solution exists. The block sits beside the solver on the same clock and shares its operand widths and its start/done handshake style.

## Interface
- X_W, 8, search variable width (signed); range −128..127
- COEF_W, 16, coefficient and target width (signed)
- ACC_W, 40, internal exact-evaluation width (signed); no overflow is possible for any input
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  request a search; sampled only in IDLE
- a, b, c  in  COEF_W each  coefficients (signed)
- y  in  COEF_W  target value (signed)
- x_found  out  X_W  smallest solution; valid when found=1, otherwise 0
- found  out  1  last search found a solution
- not_found  out  1  last search exhausted the range without a match
- busy  out  1  search in progress (EVAL1/EVAL2)
- done  out  1  one-cycle pulse at search completion

## Operation
- States: IDLE, EVAL1, EVAL2, DONE.
- IDLE:
  - On start=1, latch a, b, c, y into internal registers.
  - Set x = −128, clear found, not_found and x_found, then go to EVAL1.
  - Inputs are not re-sampled during a search.
- EVAL1: p <= sext(A)·x + sext(B), held in an ACC_W register. Go to EVAL2.
- EVAL2: compute v = p·x + sext(C) combinationally and compare it against sext(Y) at full ACC_W width. Truncated equality must never count as a match.
  - Match: x_found <= x, found <= 1, go to DONE.
  - No match and x == 127: not_found <= 1, go to DONE.
  - Otherwise: x <= x + 1, go to EVAL1.
- DONE: done = 1 for exactly this cycle, then return to IDLE.
- found, not_found and x_found hold their values until the next accepted start or reset.
- start is ignored while in EVAL1, EVAL2 or DONE.
- start held high continuously re-arms the block: a new search begins on the first IDLE cycle after DONE.
- Search order is strictly ascending, so the first match is the smallest root.
- The all-zero polynomial with Y = 0 matches at X = −128.

## Timing
- Reset values: state = IDLE; x_found = 0; found = 0; not_found = 0; busy = 0; done = 0; internal registers = 0.
- Reset asserted mid-search aborts immediately. No done pulse is produced.
- Edge numbering: the rising edge that samples start is edge 0.
- Each candidate takes 2 cycles. For candidate k = X + 128:
  - Match decision is taken at edge 2 + 2k.
  - done, found and x_found are visible after that edge. done is high for the following cycle.
- No solution: decision at edge 512; not_found = 1 and done pulse after edge 512.
- busy = 1 from after edge 0 until the edge that enters DONE. busy = 0 in DONE and IDLE.
- The earliest next start is accepted one cycle after DONE, at the first IDLE sampling edge.

## Structure
- Shared package expression_pkg holds:
  - X_W, COEF_W, ACC_W
  - a state enum {IDLE, EVAL1, EVAL2, DONE}
  - X_MIN = −128 and X_MAX = 127
- The solver reuses the same package.
- Sub-module horner_step computes acc·x + k, signed, ACC_W out, purely combinational. It is instantiated once and shared by EVAL1 (acc = A, k = B) and EVAL2 (acc = p, k = C).
- The top level contains the FSM, the x counter, the operand/target registers and the p register.

## Test plan
- A=3, B=3, C=3, Y=9 -> roots −2 and 1. Expect x_found = −2, found = 1, done pulse after edge 254, busy low from then.
- A=0, B=0, C=5, Y=5 -> x_found = −128, found = 1, done after edge 2.
- A=0, B=0, C=1, Y=0 -> not_found = 1, found = 0, x_found = 0, done after edge 512.
- A=4, B=0, C=0, Y=0 -> X = −128 gives 65536, whose low 16 bits equal 0 but which must not match. Expect x_found = 0, done after edge 258.
- Start pulsed again during a search (A=1, B=0, C=−1, Y=0) -> ignored. Expect x_found = −1, done after edge 256, exactly one done pulse.
- Drive rst low at edge 100 of a search, release it, then start A=1, B=0, C=0, Y=1 -> all outputs 0 during reset and no done pulse. The new search gives x_found = −1, done after edge 256 of the new search.

Source files
------------

// File: rtl/expression_pkg.sv
// rtl/expression_pkg.sv - shared widths, bounds, state encoding and sign-extension helper
package expression_pkg;

  localparam int X_W    = 8;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 40;

  localparam logic signed [X_W-1:0] X_MIN = {1'b1, {(X_W-1){1'b0}}};
  localparam logic signed [X_W-1:0] X_MAX = {1'b0, {(X_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL1 = 2'd1,
    EVAL2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic signed [ACC_W-1:0] sext_coef(input logic signed [COEF_W-1:0] v);
    return {{(ACC_W-COEF_W){v[COEF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/expression_root_finder_if.sv
// rtl/expression_root_finder_if.sv - start/done search handshake with coefficients and result
interface expression_root_finder_if;
  import expression_pkg::*;

  logic                     start;
  logic signed [COEF_W-1:0] a;
  logic signed [COEF_W-1:0] b;
  logic signed [COEF_W-1:0] c;
  logic signed [COEF_W-1:0] y;
  logic signed [X_W-1:0]    x_found;
  logic                     found;
  logic                     not_found;
  logic                     busy;
  logic                     done;

  modport master (
    output start, a, b, c, y,
    input  x_found, found, not_found, busy, done
  );

  modport slave (
    input  start, a, b, c, y,
    output x_found, found, not_found, busy, done
  );

endinterface

// File: rtl/expression_root_finder_horner_step.sv
// rtl/expression_root_finder_horner_step.sv - one Horner step acc*x + k at full ACC_W width
module horner_step
  import expression_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [X_W-1:0]   x,
  input  logic signed [ACC_W-1:0] k,
  output logic signed [ACC_W-1:0] res
);

  logic signed [ACC_W-1:0] x_ext;

  assign x_ext = {{(ACC_W-X_W){x[X_W-1]}}, x};
  assign res   = acc * x_ext + k;

endmodule

// File: rtl/expression_root_finder.sv
// rtl/expression_root_finder.sv - ascending search over signed X for A*X^2+B*X+C == Y
module expression_root_finder
  import expression_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  expression_root_finder_if.slave bus
);

  state_e                   state_q, state_d;
  logic signed [COEF_W-1:0] a_q, a_d;
  logic signed [COEF_W-1:0] b_q, b_d;
  logic signed [COEF_W-1:0] c_q, c_d;
  logic signed [COEF_W-1:0] y_q, y_d;
  logic signed [X_W-1:0]    x_q, x_d;
  logic signed [ACC_W-1:0]  p_q, p_d;
  logic signed [X_W-1:0]    x_found_q, x_found_d;
  logic                     found_q, found_d;
  logic                     not_found_q, not_found_d;

  logic signed [ACC_W-1:0]  step_acc;
  logic signed [ACC_W-1:0]  step_k;
  logic signed [ACC_W-1:0]  step_res;
  logic                     match;

  // One multiplier serves both Horner steps: EVAL1 forms A*x+B, EVAL2 forms p*x+C.
  always_comb begin
    step_acc = p_q;
    step_k   = sext_coef(c_q);
    if (state_q == EVAL1) begin
      step_acc = sext_coef(a_q);
      step_k   = sext_coef(b_q);
    end
  end

  horner_step u_step (
    .acc (step_acc),
    .x   (x_q),
    .k   (step_k),
    .res (step_res)
  );

  // Full-width compare so a value that only aliases Y in its low bits never matches.
  assign match = (step_res == sext_coef(y_q));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    y_d         = y_q;
    x_d         = x_q;
    p_d         = p_q;
    x_found_d   = x_found_q;
    found_d     = found_q;
    not_found_d = not_found_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d         = bus.a;
          b_d         = bus.b;
          c_d         = bus.c;
          y_d         = bus.y;
          x_d         = X_MIN;
          p_d         = '0;
          x_found_d   = '0;
          found_d     = 1'b0;
          not_found_d = 1'b0;
          state_d     = EVAL1;
        end
      end
      EVAL1: begin
        p_d     = step_res;
        state_d = EVAL2;
      end
      EVAL2: begin
        if (match) begin
          x_found_d = x_q;
          found_d   = 1'b1;
          state_d   = DONE;
        end else if (x_q == X_MAX) begin
          not_found_d = 1'b1;
          state_d     = DONE;
        end else begin
          x_d     = x_q + X_W'(1);
          state_d = EVAL1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      y_q         <= '0;
      x_q         <= '0;
      p_q         <= '0;
      x_found_q   <= '0;
      found_q     <= 1'b0;
      not_found_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      y_q         <= y_d;
      x_q         <= x_d;
      p_q         <= p_d;
      x_found_q   <= x_found_d;
      found_q     <= found_d;
      not_found_q <= not_found_d;
    end
  end

  assign bus.x_found   = x_found_q;
  assign bus.found     = found_q;
  assign bus.not_found = not_found_q;
  assign bus.busy      = (state_q == EVAL1) || (state_q == EVAL2);
  assign bus.done      = (state_q == DONE);

endmodule
